// File: rtl/bpu_pkg.sv
// Shared definitions for the BPU instruction-SRAM loader and controller.
package bpu_pkg;

  // Default datapath widths
  localparam int unsigned DefAddrW = 11;
  localparam int unsigned DefDataW = 16;

  // Instruction-SRAM control word layout: {WEN, CEN, addr}
  localparam int unsigned CtrlAddrLsb = 0;
  localparam int unsigned CtrlAddrMsb = 10;
  localparam int unsigned CtrlCenBit  = 11;
  localparam int unsigned CtrlWenBit  = 12;

  // NULL opcode
  localparam logic [4:0] OpNull = 5'b00000;

  // Loader FSM states
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StRun,
    StErr
  } ld_state_e;

endpackage

// File: rtl/bpu_sram_wr_stage.sv
// Registered SRAM write stage: a strobe captures addr/data and drives CEN/WEN low for one cycle.
// Between writes the port is idle and addr/data hold their last values.
module bpu_sram_wr_stage #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [ADDR_W+1:0] ctrl,
  output logic [DATA_W-1:0] wdata
);

  logic [ADDR_W-1:0] addr_q;
  logic              cen_q;
  logic              wen_q;

  // One-cycle write pulse per strobe; address and data hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
      wdata  <= '0;
    end else if (strobe) begin
      addr_q <= addr;
      cen_q  <= 1'b0;
      wen_q  <= 1'b0;
      wdata  <= data;
    end else begin
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
    end
  end

  assign ctrl = {wen_q, cen_q, addr_q};

endmodule

// File: rtl/bpu_prog_loader.sv
// Program loader: streams instruction words into instruction SRAM from address 0 while holding
// the BPU controller in reset, then releases it to fetch from PC 0.
// Optional feature macro: BPU_PROG_LOADER_CSUM_EN (mod-2^16 checksum of the loaded words).
module bpu_prog_loader
  import bpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [ADDR_W+1:0] instsram_ctrl,
  output logic [DATA_W-1:0] instsram_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   prog_len,
  output logic [DATA_W-1:0] prog_csum
);

  // Pointer value of the last in-range SRAM word
  localparam logic [ADDR_W:0] LastPtr = (ADDR_W+1)'(DEPTH - 1);

  ld_state_e       state;
  logic [ADDR_W:0] wr_ptr;
  logic            hs;
  logic            start_ok;

  assign hs       = in_valid & in_ready;
  // load_start is only honoured outside an active load
  assign start_ok = load_start & ((state == StIdle) | (state == StRun) | (state == StErr));

  // Loader FSM with registered handshake, reset and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      in_ready <= 1'b0;
      wr_ptr   <= '0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
      prog_len <= '0;
    end else begin
      unique case (state)
        StIdle, StRun, StErr: begin
          if (start_ok) begin
            state    <= StLoad;
            in_ready <= 1'b1;
            wr_ptr   <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        StLoad: begin
          if (hs) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (in_last) begin
              state    <= StFlush;
              in_ready <= 1'b0;
            end else if (wr_ptr == LastPtr) begin
              // Word at DEPTH-1 is still written; anything beyond is refused
              state    <= StErr;
              in_ready <= 1'b0;
              overflow <= 1'b1;
            end
          end
        end
        StFlush: begin
          // Final write is on the SRAM port this cycle; wr_ptr is now the word count
          prog_len <= wr_ptr;
          state    <= StRun;
          core_rst <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state    <= StIdle;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  bpu_sram_wr_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_stage (
    .clk    (clk),
    .rst    (rst),
    .strobe (hs),
    .addr   (wr_ptr[ADDR_W-1:0]),
    .data   (in_data),
    .ctrl   (instsram_ctrl),
    .wdata  (instsram_wdata)
  );

`ifdef BPU_PROG_LOADER_CSUM_EN
  logic [DATA_W-1:0] csum;

  // Running sum of accepted words, cleared when a new load begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (hs) begin
      csum <= csum + in_data;
    end
  end

  assign prog_csum = csum;
`else
  assign prog_csum = '0;
`endif

endmodule

// File: tb/tb_bpu_prog_loader.sv
// Self-checking bench for bpu_prog_loader: randomized streams checked every cycle against a
// behavioural model, plus hand-computed expectations for the directed scenarios.
module tb_bpu_prog_loader;
  import bpu_pkg::*;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 2048;

  localparam int PIdle  = 0;
  localparam int PLoad  = 1;
  localparam int PFlush = 2;
  localparam int PRun   = 3;
  localparam int PErr   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW+1:0] instsram_ctrl;
  logic [DW-1:0] instsram_wdata;
  logic          core_rst;
  logic          done;
  logic          overflow;
  logic [AW:0]   prog_len;
  logic [DW-1:0] prog_csum;

  bpu_prog_loader dut (
    .clk            (clk),
    .rst            (rst),
    .load_start     (load_start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .instsram_ctrl  (instsram_ctrl),
    .instsram_wdata (instsram_wdata),
    .core_rst       (core_rst),
    .done           (done),
    .overflow       (overflow),
    .prog_len       (prog_len),
    .prog_csum      (prog_csum)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           wq[$];
  logic [DW-1:0] words[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: load phase, words accepted, pending write, length and checksum
  int            ph = PIdle;
  int            m_ptr = 0;
  bit            m_pend = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_len = 0;
  logic [DW-1:0] m_csum = '0;

  initial begin
    bit nxt_pend;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = PIdle; m_ptr = 0; m_pend = 1'b0; m_addr = '0; m_wdata = '0;
        m_len = 0; m_csum = '0;
      end
      chk("in_ready", 32'(in_ready), 32'(ph == PLoad));
      chk("core_rst", 32'(core_rst), 32'(ph != PRun));
      chk("done", 32'(done), 32'(ph == PRun));
      chk("overflow", 32'(overflow), 32'(ph == PErr));
      chk("cen", 32'(instsram_ctrl[CtrlCenBit]), 32'(!m_pend));
      chk("wen", 32'(instsram_ctrl[CtrlWenBit]), 32'(!m_pend));
      chk("addr", 32'(instsram_ctrl[CtrlAddrMsb:CtrlAddrLsb]), 32'(m_addr));
      chk("wdata", 32'(instsram_wdata), 32'(m_wdata));
      chk("prog_len", 32'(prog_len), 32'(m_len));
`ifdef BPU_PROG_LOADER_CSUM_EN
      chk("prog_csum", 32'(prog_csum), 32'(m_csum));
`else
      chk("prog_csum", 32'(prog_csum), 32'd0);
`endif
      if (instsram_ctrl[CtrlCenBit] == 1'b0)
        wq.push_back('{a: instsram_ctrl[CtrlAddrMsb:CtrlAddrLsb], d: instsram_wdata});
      if (!rst) begin
        nxt_pend = 1'b0;
        if (ph == PLoad && in_valid) begin
          nxt_pend = 1'b1;
          m_addr   = AW'(m_ptr % DEPTH);
          m_wdata  = in_data;
          m_csum   = m_csum + in_data;
          m_ptr++;
          if (in_last) ph = PFlush;
          else if (m_ptr == DEPTH) ph = PErr;
        end else if (ph == PFlush) begin
          m_len = m_ptr;
          ph    = PRun;
        end else if (ph != PLoad && load_start) begin
          ph     = PLoad;
          m_ptr  = 0;
          m_csum = '0;
        end
        m_pend = nxt_pend;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    words.delete();
    repeat (n) words.push_back(DW'($urandom));
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid with stray load_start
  task automatic send_words(input bit use_last, input int mode);
    int idx   = 0;
    int stall = 0;
    bit alt   = 1'b0;
    bit v;
    bit r;
    while (idx < words.size()) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = alt; alt = !alt; end
        default: v = ($urandom_range(0, 99) < 60);
      endcase
      in_valid = v;
      in_data  = words[idx];
      in_last  = use_last && (idx == words.size() - 1);
      if (mode == 2) load_start = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      r = in_ready;
      tick();
      load_start = 1'b0;
      if (v && r) begin
        idx++;
        stall = 0;
      end else if (v) begin
        stall++;
        if (stall > 20) begin
          chk("accept_timeout", 32'(idx), 32'(words.size()));
          break;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_ctrl", 32'(instsram_ctrl), 32'h1800);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Three-word program, continuous valid
    words = '{16'h0801, 16'h0922, 16'h3003};
    wq.delete();
    pulse_start();
    send_words(1'b1, 0);
    wait_done();
    chk("t1_len", 32'(prog_len), 32'd3);
    chk("t1_core_rst", 32'(core_rst), 32'd0);
    chk("t1_nwr", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      chk("t1_a0", 32'(wq[0].a), 32'd0);
      chk("t1_d0", 32'(wq[0].d), 32'h0801);
      chk("t1_a1", 32'(wq[1].a), 32'd1);
      chk("t1_d1", 32'(wq[1].d), 32'h0922);
      chk("t1_a2", 32'(wq[2].a), 32'd2);
      chk("t1_d2", 32'(wq[2].d), 32'h3003);
    end

    // Reload from RUN with gapped valid
    wq.delete();
    pulse_start();
    @(negedge clk);
    chk("t2_core_rst", 32'(core_rst), 32'd1);
    chk("t2_done", 32'(done), 32'd0);
    tick();
    send_words(1'b1, 1);
    wait_done();
    chk("t2_len", 32'(prog_len), 32'd3);
    chk("t2_nwr", 32'(wq.size()), 32'd3);

    // Full-depth program ending exactly at the last address
    fill_rand(DEPTH);
    wq.delete();
    pulse_start();
    send_words(1'b1, 0);
    wait_done();
    chk("t3_len", 32'(prog_len), 32'd2048);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_nwr", 32'(wq.size()), 32'd2048);
    if (wq.size() > 0) chk("t3_last_addr", 32'(wq[$].a), 32'd2047);

    // Full-depth program without in_last overflows
    fill_rand(DEPTH);
    wq.delete();
    pulse_start();
    send_words(1'b0, 0);
    in_valid = 1'b1;
    in_data  = 16'hbeef;
    repeat (3) tick();
    @(negedge clk);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_core_rst", 32'(core_rst), 32'd1);
    chk("t4_len_kept", 32'(prog_len), 32'd2048);
    chk("t4_nwr", 32'(wq.size()), 32'd2048);
    if (wq.size() > 0) chk("t4_last_addr", 32'(wq[$].a), 32'd2047);
    tick();
    in_valid = 1'b0;

    // Reset arriving with the 5th word of a 10-word load
    fill_rand(4);
    pulse_start();
    send_words(1'b0, 0);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    rst      = 1'b1;
    @(negedge clk);
    chk("t5_ctrl", 32'(instsram_ctrl), 32'h1800);
    chk("t5_wdata", 32'(instsram_wdata), 32'd0);
    chk("t5_core_rst", 32'(core_rst), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_len", 32'(prog_len), 32'd0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    fill_rand(2);
    pulse_start();
    send_words(1'b1, 2);
    wait_done();
    chk("t5_len2", 32'(prog_len), 32'd2);

    // load_start during LOAD is ignored
    fill_rand(2);
    pulse_start();
    send_words(1'b0, 0);
    pulse_start();
    fill_rand(3);
    send_words(1'b1, 0);
    wait_done();
    chk("t6_len", 32'(prog_len), 32'd5);

    // Random program lengths and valid patterns
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 40);
      fill_rand(n);
      pulse_start();
      send_words(1'b1, 2);
      wait_done();
      chk("rand_len", 32'(prog_len), 32'(n));
    end

`ifdef BPU_PROG_LOADER_CSUM_EN
    words = '{16'hffff, 16'h0002};
    pulse_start();
    send_words(1'b1, 0);
    wait_done();
    chk("csum_wrap", 32'(prog_csum), 32'h0001);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bpu_prog_loader.md
Name: bpu_prog_loader

Overview:
- Writer side of the instruction SRAM: accepts a 16-bit instruction stream over a valid/ready handshake and writes it into instruction SRAM from address 0.
- Holds the BPU controller in reset while loading, then releases it so the controller fetches from PC 0.
- Drives the same 13-bit instruction-SRAM control word format that the controller drives: addr[10:0], CEN[11], WEN[12].

Parameters:
- ADDR_W, 11, instruction SRAM address width.
- DEPTH, 2048, instruction SRAM words; must equal 2**ADDR_W.
- DATA_W, 16, instruction width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- load_start  in  1  single-cycle pulse that begins a program load
- in_valid  in  1  stream word valid
- in_ready  out  1  loader can accept a word
- in_data  in  DATA_W  instruction word
- in_last  in  1  marks the final word of the program
- instsram_ctrl  out  ADDR_W+2  [10:0] addr, [11] CEN (active-low), [12] WEN (active-low)
- instsram_wdata  out  DATA_W  SRAM write data
- core_rst  out  1  reset to the BPU controller, active-high
- done  out  1  program loaded, controller running
- overflow  out  1  program exceeded DEPTH without in_last
- prog_len  out  ADDR_W+1  number of words written by the last completed load
- prog_csum  out  DATA_W  checksum; present only with the optional feature

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE, in_ready 0
  - instsram_ctrl: addr 0, CEN 1, WEN 1
  - instsram_wdata 0
  - core_rst 1, done 0, overflow 0
  - prog_len 0, prog_csum 0
- FSM states: IDLE, LOAD, FLUSH, RUN, ERR.
- IDLE:
  - in_ready 0; in_valid is ignored.
  - load_start -> LOAD; clear wr_ptr, overflow and done.
- LOAD:
  - in_ready 1.
  - A handshake (in_valid & in_ready) captures the word. On the next cycle the loader drives CEN=0, WEN=0, addr=wr_ptr, wdata=word. Write latency is 1 cycle.
  - wr_ptr increments on each handshake.
  - No handshake: the next cycle drives CEN=1, WEN=1; addr holds its last value.
  - load_start is ignored in LOAD.
- Ending a load:
  - Handshake with in_last -> FLUSH; in_ready drops the cycle after.
  - Handshake without in_last at wr_ptr == DEPTH-1 -> ERR.
  - A DEPTH-word program ending with in_last at address DEPTH-1 is legal.
- FLUSH:
  - Lasts one cycle; the final write is on the SRAM port.
  - prog_len <= wr_ptr (the word count), then -> RUN.
- RUN:
  - core_rst 0, done 1; SRAM port idle (CEN=1, WEN=1).
  - load_start -> LOAD: core_rst reasserts and done clears on the next edge, before any SRAM write is issued.
- ERR:
  - overflow 1, core_rst 1, in_ready 0. The final in-range write (address DEPTH-1) still completes.
  - prog_len is unchanged.
  - Only load_start (-> LOAD) or rst leaves ERR.
- Reset mid-load: asynchronous return to all reset values. SRAM contents are left partially written; core_rst stays 1 until a complete load.
- wr_ptr is ADDR_W+1 bits wide and does not wrap inside LOAD; addr = wr_ptr[ADDR_W-1:0].

Optional Feature:
- Macro: BPU_PROG_LOADER_CSUM_EN.
- Defined:
  - prog_csum holds the mod-2^16 sum of all words accepted in the current load.
  - Cleared on load_start; updated on each handshake.
  - Valid when done rises, then held until the next load_start.
- Undefined: the prog_csum port is tied to 0 and no accumulator is built.

Decomposition:
- Shared package bpu_pkg:
  - FSM state enum.
  - Instruction-SRAM control field indices: ADDR lsb/msb, CEN bit 11, WEN bit 12.
  - Default ADDR_W and DATA_W.
  - NULL opcode 5'b00000.
- No sub-module is required. The registered SRAM write stage may be split out as bpu_sram_wr_stage: capture addr/data on strobe, drive CEN/WEN low for one cycle.

Test Plan:
- Reset, then load_start and 3 words 16'h0801, 16'h0922, 16'h3003 (last on the third) -> writes to addr 0,1,2, each one cycle after its handshake; FLUSH; done=1, core_rst=0, prog_len=3.
- Same load with in_valid gapped every other cycle -> writes only after handshakes, CEN=1 in gap cycles, prog_len=3.
- 2048 words with last on word 2048 -> last write at addr 2047, prog_len=2048, overflow=0. 2048 words without last -> overflow=1, in_ready=0, core_rst=1, next word not accepted.
- Assert rst at the 5th word of a 10-word load -> next cycle all outputs at reset values, CEN=1. A new load of 2 words completes with prog_len=2.
- In RUN, pulse load_start -> core_rst=1 and done=0 on the next edge. A load_start pulsed during LOAD has no effect.
- With BPU_PROG_LOADER_CSUM_EN: words 16'hFFFF, 16'h0002 -> prog_csum=16'h0001 at done.
